// File: rtl/aes_subbytes_engine_if.sv
// Block handshake bundle for the SubBytes engine: one 128-bit state in, one out.
// The engine takes the slave side; the producer/consumer side takes master.
interface aes_subbytes_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_subbytes_engine.sv
// AES forward SubBytes over a 128-bit state, LANES S-boxes reused over 16/LANES steps.
// Accepts one block in IDLE, fills the result in BUSY, presents it in DONE.
module aes_subbytes_engine #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_subbytes_engine_if.slave  bus,
  output logic                  busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] step_q;
  logic [127:0]  src_q, result_q;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    // NOTE: blocking '=' is right here: function locals are combinational temporaries.
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (= x^(2+4+...+128)), which also maps 0 to 0, then the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l]  = src_q[(int'(step_q) * LANES + l) * 8 +: 8];
    assign lane_out[l] = sbox(lane_in[l]);
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = BUSY;
      BUSY:    if (step_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking '<=' for all registered state so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Step k writes bytes k*LANES .. k*LANES+LANES-1; all other result bytes hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide source/result registers are reset too, so an abandoned block never reaches out_data.
      step_q   <= '0;
      src_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          src_q  <= bus.in_data;
          step_q <= '0;
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++)
            result_q[(int'(step_q) * LANES + l) * 8 +: 8] <= lane_out[l];
          if (step_q != LAST) step_q <= step_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = result_q;
  assign busy          = (state_q != IDLE);

endmodule
